// File: rtl/signed_scan_display_pkg.sv
// ============================================================================
//  Module      : signed_scan_display_pkg
//  Description : Shared definitions for the signed scanned display: segment
//                code table, blank pattern, FSM state encoding and the helper
//                that sizes the BCD register from the input width.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package signed_scan_display_pkg;

  // Segment pattern for a blanked digit.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Nibble-indexed segment patterns, entry 0 first.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1110111, 7'b0010010, 7'b1011101, 7'b1011011,
    7'b0111010, 7'b1101011, 7'b1101111, 7'b1010010,
    7'b1111111, 7'b1111011, 7'b1111110, 7'b0101111,
    7'b1100101, 7'b0011111, 7'b1101101, 7'b1101100
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Number of decimal digits of 2^(width-1), the largest possible magnitude.
  function automatic int calc_nbcd(input int width);
    logic [63:0] v;
    int          n;
    v = 64'd1 << (width - 1);
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential shift-add-3 binary to BCD converter. One input
//                bit is consumed per clock; the result is valid WIDTH cycles
//                after start and is held until the next start.
//  Ports       : clk, rst   clock, synchronous active-high reset
//                start      load bin and begin a conversion
//                bin        unsigned value to convert
//                done       high during the cycle whose edge performs the
//                           final step (bcd is final after that edge)
//                bcd        NBCD packed BCD digits, digit 0 in bits [3:0]
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import signed_scan_display_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NBCD  = calc_nbcd(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin,
  output logic              done,
  output logic [4*NBCD-1:0] bcd
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  shreg;
  logic [CNT_W-1:0]  cnt;
  logic              running;
  logic [4*NBCD-1:0] bcd_next;

  // Adjust-then-shift per digit. A digit >= 5 becomes digit+3, whose bit 3
  // is the carry into the next digit and whose low bits equal digit-5.
  for (genvar d = 0; d < NBCD; d++) begin : g_digit
    logic [3:0] cur;
    logic       cin;
    assign cur = bcd[4*d +: 4];
    if (d == 0) begin : g_lsd
      assign cin = shreg[WIDTH-1];
    end else begin : g_upper
      assign cin = (bcd[4*(d-1) +: 4] >= 4'd5);
    end
    assign bcd_next[4*d +: 4] = {(cur >= 4'd5) ? 3'(cur - 4'd5) : cur[2:0], cin};
  end

  assign done = running && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      shreg   <= '0;
      bcd     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      shreg   <= bin;
      bcd     <= '0;
    end else if (running) begin
      bcd   <= bcd_next;
      shreg <= shreg << 1;
      cnt   <= cnt + 1'b1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/signed_scan_display.sv
// ============================================================================
//  Module      : signed_scan_display
//  Description : Captures a signed value, converts its magnitude to hex or
//                decimal digits and time-multiplexes them onto a shared
//                7-segment bus with sign, overflow and leading-zero blanking.
//  Ports       : clk, rst   clock, synchronous active-high reset
//                data_in    signed value, sampled on an accepted load
//                load       request, accepted only while busy=0
//                mode       0 = hex, 1 = decimal (sampled with load)
//                busy       conversion/latch in progress
//                done       one-cycle pulse when the new value is displayed
//                seg        segment pattern of the enabled digit
//                digit_en   one-hot digit select, bit 0 = least significant
//                sign       displayed value is negative
//                ovf        magnitude does not fit in DIGITS digits
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module signed_scan_display
  import signed_scan_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000,
  parameter int LZB      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              load,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_en,
  output logic              sign,
  output logic              ovf
);

  localparam int NBCD  = calc_nbcd(WIDTH);
  localparam int NHEX  = (WIDTH + 3) / 4;
  localparam int NMAX0 = (NBCD > NHEX) ? NBCD : NHEX;
  localparam int NALL  = (NMAX0 > DIGITS) ? NMAX0 : DIGITS;
  localparam int VW    = 4 * NALL;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                  state;
  logic                    sign_cap;
  logic                    mode_cap;
  logic [WIDTH-1:0]        mag_cap;
  logic [WIDTH-1:0]        mag;
  logic                    accept;
  logic                    conv_done;
  logic [4*NBCD-1:0]       bcd;
  logic [VW-1:0]           vec;
  logic                    ovf_next;
  logic [DIGITS-1:0][3:0]  disp;
  logic [DIGITS-1:0]       blank;
  logic [CNT_W-1:0]        scan_cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              sel;
  logic                    sel_blank;

  // Unsigned negation is exact for the most negative input (-2^(W-1)).
  assign mag    = data_in[WIDTH-1] ? (-data_in) : data_in;
  assign accept = load && (state == ST_IDLE);

  bin2bcd_seq #(
    .WIDTH (WIDTH),
    .NBCD  (NBCD)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept && mode),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Candidate digits, zero-extended to cover every digit position that could
  // be nonzero as well as every displayed digit.
  assign vec = mode_cap ? VW'(bcd) : VW'(mag_cap);

  if (NALL > DIGITS) begin : g_ovf
    assign ovf_next = |vec[VW-1:4*DIGITS];
  end else begin : g_no_ovf
    assign ovf_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      ovf      <= 1'b0;
      disp     <= '0;
      sign_cap <= 1'b0;
      mode_cap <= 1'b0;
      mag_cap  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            sign_cap <= data_in[WIDTH-1];
            mag_cap  <= mag;
            mode_cap <= mode;
            busy     <= 1'b1;
            state    <= mode ? ST_CONV : ST_LATCH;
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          // Display registers only change here, so the old value stays up
          // for the whole conversion.
          disp  <= vec[4*DIGITS-1:0];
          sign  <= sign_cap;
          ovf   <= ovf_next;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Leading-zero run from the top digit down; digit 0 is never blanked and
  // an overflowing value is always shown in full.
  always_comb begin
    logic run;
    blank = '0;
    run   = (LZB != 0) && !ovf;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run      = run && (disp[i] == 4'd0);
      blank[i] = run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    sel       = 4'd0;
    sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel       = disp[i];
        sel_blank = blank[i];
      end
    end
  end

  // Both derive from the same registers, so they switch on the same edge.
  assign seg      = sel_blank ? SEG_BLANK : SEG_TABLE[sel];
  assign digit_en = DIGITS'(1) << idx;

endmodule

`default_nettype wire

// File: doc/signed_scan_display.md
# signed_scan_display

Parametrised successor to the team's single-digit signed segment decoder. It captures a WIDTH-bit two's-complement value on a load handshake and converts its magnitude to hexadecimal or decimal digits; decimal conversion is sequential (shift-add-3). It then time-multiplexes DIGITS segment digits onto one shared 7-bit segment bus, with a separate sign output, leading-zero blanking and an overflow flag. It sits between the arithmetic datapath (e.g. the signed multiplier) and the board display.

## Interface
- WIDTH, 8, signed input width (≥2)
- DIGITS, 3, number of multiplexed magnitude digits (≥1)
- SCAN_DIV, 1000, clock cycles each digit stays enabled (≥1)
- LZB, 1, 1 = blank leading zero digits above digit 0
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  WIDTH  signed value to display
- load  in  1  request; accepted only when busy=0
- mode  in  1  0 = hex, 1 = decimal; sampled with load
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse: new value now displayed
- seg  out  7  segment pattern of currently enabled digit
- digit_en  out  DIGITS  one-hot active-high digit select, bit 0 = least significant
- sign  out  1  1 = displayed value negative
- ovf  out  1  magnitude does not fit in DIGITS digits

## Operation
- Segment code table, nibble → seg: 0 1110111, 1 0010010, 2 1011101, 3 1011011, 4 0111010, 5 1101011, 6 1101111, 7 1010010, 8 1111111, 9 1111011, A 1111110, B 0101111, C 1100101, D 0011111, E 1101101, F 1101100. A blank digit drives 0000000.
- On accept, the block captures sign = data_in[WIDTH-1] and mag = |data_in| as a WIDTH-bit unsigned value. The most negative value is exact: -128 at WIDTH=8 gives mag 128.
- FSM states are IDLE, CONV and LATCH.
  - IDLE: on load, go to LATCH if mode=0, or to CONV if mode=1.
  - CONV: runs exactly WIDTH cycles of shift-add-3 over an internal BCD register of NBCD digits, then goes to LATCH. NBCD is the number of decimal digits of 2^(WIDTH-1).
  - LATCH: copies digits, sign and ovf into the display registers, then returns to IDLE.
- Hex digits are the nibbles of mag, zero-extended.
- ovf=1 if any digit of index ≥ DIGITS is nonzero. The displayed digits are then the low DIGITS digits, and blanking is disabled.
- Blanking (LZB=1, ovf=0): digit i>0 is blank if it and all higher digits are zero. Digit 0 is never blank.
- Display registers hold the previous value throughout CONV, so there is no flicker.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On wrap, idx advances 0→1→…→DIGITS-1→0.
  - digit_en = 1<<idx.
  - seg = code(disp[idx]), or blank.
  - Scanning is independent of conversion state.

## Timing
- Reset values:
  - State IDLE; busy 0, done 0, sign 0, ovf 0.
  - All display digits 0; idx 0, scan_cnt 0.
  - Outputs: digit_en = 1, seg = 1110111.
- load is sampled at edge k with busy=0.
  - Hex: busy=1 during cycle k+1 (LATCH). New seg/sign/ovf are visible, and done=1, from edge k+2 for one cycle.
  - Decimal: busy=1 for cycles k+1 … k+WIDTH+1. The display updates and done pulses at edge k+WIDTH+2.
- load while busy=1 is ignored, with no queuing. load in the done cycle is accepted, since the FSM is back in IDLE.
- data_in and mode are don't-care except at the accept edge.
- rst mid-conversion aborts the conversion and restores all reset values.
- seg and digit_en change on the same edge, with no skew cycle.

## Structure
- Package signed_scan_display_pkg holds:
  - the 16-entry segment code table and the blank constant;
  - an FSM state enum;
  - a function computing NBCD from WIDTH.
- One sub-module, bin2bcd_seq: the sequential shift-add-3 converter with start/done and a WIDTH-cycle latency.
- The scan counter, blanking and segment mux stay in the top module.

## Test plan
- Reset, defaults → seg=1110111, digit_en=001, sign=0, busy=0, ovf=0.
- Hex, load 8'hA5 (-91, mag 0x5B) → busy for 1 cycle; done at k+2. Display: digit0 0101111, digit1 1101011, digit2 blank; sign=1.
- Decimal, load 8'h80 (-128) → busy for 9 cycles; done at k+10. Display: digit0 1111111, digit1 1011101, digit2 0010010; sign=1.
- Decimal, load 7, then a second load of 3 at the accept edge+1 → second load ignored. Display: digit0 1010010, digits 1–2 blank.
- DIGITS=2, decimal, load 100 → ovf=1; digits show 0,0 (1110111 both, not blanked).
- SCAN_DIV=4 → digit_en cycles 001→010→100→001, changing every 4 cycles. Mid-CONV rst → display returns to 0 and busy=0 next cycle.
